// File: rtl/seg7_count_display_pkg.sv
// Shared definitions for the two-digit 7-segment count display: scan state
// encoding, the dark pattern and the active-low digit pattern table.
package seg7_count_display_pkg;

   // Encoding chosen so the scan order is a plain increment and bit 0 marks blank slots.
   localparam logic [1:0] ST_DIG0   = 2'd0;
   localparam logic [1:0] ST_BLANK0 = 2'd1;
   localparam logic [1:0] ST_DIG1   = 2'd2;
   localparam logic [1:0] ST_BLANK1 = 2'd3;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
   localparam logic [6:0] SEG_PAT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

endpackage

// File: rtl/seg7_count_display_if.sv
// Display-side signal bundle: counter value in, segment/anode drive and
// debug observation out.
interface seg7_count_display_if;
   logic [3:0] val;
   logic [6:0] seg;
   logic [1:0] an;
   logic [3:0] disp_val;
   logic [1:0] dbg_state;

   modport master (output val, input seg, an, disp_val, dbg_state);
   modport slave  (input val, output seg, an, disp_val, dbg_state);
endinterface

// File: rtl/seg7_count_display_decode.sv
// Combinational BCD digit to active-low 7-segment pattern; anything above 9 is dark.
module seg7_decode
   import seg7_count_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      if (bcd <= 4'd9) seg = SEG_PAT[bcd];
   end

endmodule

// File: rtl/seg7_count_display.sv
// Synchronises and debounces the slow counter value, splits it into two
// decimal digits and scans them onto a common-anode display with blank gaps.
module seg7_count_display
   import seg7_count_display_pkg::*;
#(
   parameter int SCAN_CYCLES   = 16,
   parameter int BLANK_CYCLES  = 2,
   parameter int STABLE_CYCLES = 2,
   parameter int LZ_BLANK      = 1
) (
   input logic                 clk,
   input logic                 rst,
   seg7_count_display_if.slave bus
);

   localparam int SCAN_MAX = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
   localparam int CW       = $clog2(SCAN_MAX + 1);
   localparam int SW       = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] DIG_LAST   = CW'(SCAN_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [SW-1:0] STAB_MAX   = SW'(STABLE_CYCLES);

   logic [3:0]    s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, disp_q, disp_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] scan_q, scan_d;
   logic [6:0]    seg_q, seg_d, dec_seg;
   logic [1:0]    an_q, an_d;
   logic          tens;
   logic [3:0]    ones, dec_in;

   // Input path: a value is accepted only after STABLE_CYCLES repeats of the synchronised sample.
   always_comb begin
      s1_d   = bus.val;
      s2_d   = s1_q;
      prev_d = s2_q;
      stab_d = '0;
      if (s2_q == prev_q) stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
      disp_d = disp_q;
      if (stab_d == STAB_MAX && s2_q != disp_q) disp_d = s2_q;
   end

   always_comb begin
      tens = (disp_q >= 4'd10);
      ones = tens ? disp_q - 4'd10 : disp_q;
   end

   always_comb begin
      state_d = state_q;
      scan_d  = scan_q + 1'b1;
      if (scan_q == (state_q[0] ? BLANK_LAST : DIG_LAST)) begin
         scan_d  = '0;
         state_d = state_q + 2'd1;
      end
   end

   assign dec_in = (state_d == ST_DIG1) ? {3'b000, tens} : ones;

   seg7_decode u_decode (
      .bcd (dec_in),
      .seg (dec_seg)
   );

   // Outputs are loaded only on slot entry, so a lit digit is frozen for its whole slot.
   always_comb begin
      seg_d = seg_q;
      an_d  = an_q;
      if (state_d != state_q) begin
         seg_d = SEG_OFF;
         an_d  = 2'b11;
         if (state_d == ST_DIG0) begin
            seg_d = dec_seg;
            an_d  = 2'b10;
         end else if (state_d == ST_DIG1 && !(LZ_BLANK != 0 && !tens)) begin
            seg_d = dec_seg;
            an_d  = 2'b01;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         prev_q  <= '0;
         stab_q  <= '0;
         disp_q  <= '0;
         state_q <= ST_BLANK1;
         scan_q  <= '0;
         seg_q   <= SEG_OFF;
         an_q    <= 2'b11;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         prev_q  <= prev_d;
         stab_q  <= stab_d;
         disp_q  <= disp_d;
         state_q <= state_d;
         scan_q  <= scan_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign bus.seg       = seg_q;
   assign bus.an        = an_q;
   assign bus.disp_val  = disp_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed bench for seg7_count_display: scan timing, debounce latency,
// digit patterns, leading-zero blanking and asynchronous reset.
module tb_seg7_count_display;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc;

   seg7_count_display_if bus ();

   seg7_count_display dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; DIG0 slots start at edge 2, 38, 74, ...
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   function automatic int phase();
      return (cyc + 34) % 36;
   endfunction

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         checks++;
         if (bus.an === 2'b00) begin
            errors++;
            $display("FAIL an_never_00: an=%b required not 00", bus.an);
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_phase(input int target);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (phase() != target && n < 200);
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL wait_phase: phase %0d not reached", target);
      end
   endtask

   task automatic test_reset;
      rst     = 1'b0;
      bus.val = 4'd0;
      step(3);
      checks += 3;
      if (bus.seg !== 7'h7F) begin errors++; $display("FAIL rst_seg: got %h exp 7f", bus.seg); end
      if (bus.an !== 2'b11) begin errors++; $display("FAIL rst_an: got %b exp 11", bus.an); end
      if (bus.disp_val !== 4'd0) begin errors++; $display("FAIL rst_disp: got %0d exp 0", bus.disp_val); end
      rst = 1'b1;
      step(1);
      checks++;
      if (bus.an !== 2'b11 || bus.seg !== 7'h7F) begin
         errors++; $display("FAIL first_blank: an=%b seg=%h exp 11/7f", bus.an, bus.seg);
      end
      step(1);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (bus.an !== 2'b10 || bus.seg !== 7'h40) begin
            errors++; $display("FAIL dig0_zero: cyc %0d an=%b seg=%h exp 10/40", i, bus.an, bus.seg);
         end
         step(1);
      end
      wait_phase(18);
      checks += 2;
      if (bus.an !== 2'b11 || bus.seg !== 7'h7F) begin
         errors++; $display("FAIL tens_lz0: an=%b seg=%h exp 11/7f", bus.an, bus.seg);
      end
      if (bus.disp_val !== 4'd0) begin errors++; $display("FAIL disp0: got %0d exp 0", bus.disp_val); end
   endtask

   task automatic test_val7;
      bus.val = 4'd7;
      step(4);
      checks++;
      if (bus.disp_val !== 4'd0) begin errors++; $display("FAIL lat_early: got %0d exp 0", bus.disp_val); end
      step(1);
      checks++;
      if (bus.disp_val !== 4'd7) begin errors++; $display("FAIL lat_5: got %0d exp 7", bus.disp_val); end
      wait_phase(0);
      checks++;
      if (bus.an !== 2'b10 || bus.seg !== 7'h78) begin
         errors++; $display("FAIL dig0_7: an=%b seg=%h exp 10/78", bus.an, bus.seg);
      end
      wait_phase(18);
      checks++;
      if (bus.an !== 2'b11 || bus.seg !== 7'h7F) begin
         errors++; $display("FAIL tens_lz7: an=%b seg=%h exp 11/7f", bus.an, bus.seg);
      end
   endtask

   task automatic test_val12;
      logic [1:0] exp_an;
      logic [6:0] exp_seg;
      int p;
      bus.val = 4'd12;
      step(5);
      checks++;
      if (bus.disp_val !== 4'd12) begin errors++; $display("FAIL disp12: got %0d exp 12", bus.disp_val); end
      wait_phase(0);
      for (int i = 0; i < 36; i++) begin
         p = phase();
         if (p < 16)      begin exp_an = 2'b10; exp_seg = 7'h24; end
         else if (p < 18) begin exp_an = 2'b11; exp_seg = 7'h7F; end
         else if (p < 34) begin exp_an = 2'b01; exp_seg = 7'h79; end
         else             begin exp_an = 2'b11; exp_seg = 7'h7F; end
         checks++;
         if (bus.an !== exp_an || bus.seg !== exp_seg) begin
            errors++;
            $display("FAIL frame12: phase %0d an=%b seg=%h exp %b/%h", p, bus.an, bus.seg, exp_an, exp_seg);
         end
         step(1);
      end
   endtask

   task automatic test_glitch;
      for (int i = 0; i < 20; i++) begin
         bus.val = (i % 2 == 0) ? 4'd4 : 4'd3;
         step(1);
         checks++;
         if (bus.disp_val !== 4'd12) begin
            errors++; $display("FAIL glitch_hold: step %0d got %0d exp 12", i, bus.disp_val);
         end
      end
      bus.val = 4'd4;
      step(4);
      checks++;
      if (bus.disp_val !== 4'd12) begin errors++; $display("FAIL settle_early: got %0d exp 12", bus.disp_val); end
      step(1);
      checks++;
      if (bus.disp_val !== 4'd4) begin errors++; $display("FAIL settle4: got %0d exp 4", bus.disp_val); end
   endtask

   task automatic test_wrap;
      bus.val = 4'd15;
      step(6);
      checks++;
      if (bus.disp_val !== 4'd15) begin errors++; $display("FAIL disp15: got %0d exp 15", bus.disp_val); end
      wait_phase(0);
      bus.val = 4'd0;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (bus.an !== 2'b10 || bus.seg !== 7'h12) begin
            errors++; $display("FAIL wrap_hold: phase %0d an=%b seg=%h exp 10/12", i, bus.an, bus.seg);
         end
         if (i < 15) step(1);
      end
      checks++;
      if (bus.disp_val !== 4'd0) begin errors++; $display("FAIL wrap_disp: got %0d exp 0", bus.disp_val); end
      wait_phase(18);
      checks++;
      if (bus.an !== 2'b11 || bus.seg !== 7'h7F) begin
         errors++; $display("FAIL wrap_tens: an=%b seg=%h exp 11/7f", bus.an, bus.seg);
      end
      wait_phase(0);
      checks++;
      if (bus.an !== 2'b10 || bus.seg !== 7'h40) begin
         errors++; $display("FAIL wrap_dig0: an=%b seg=%h exp 10/40", bus.an, bus.seg);
      end
   endtask

   task automatic test_reset_mid;
      bus.val = 4'd13;
      step(6);
      checks++;
      if (bus.disp_val !== 4'd13) begin errors++; $display("FAIL disp13: got %0d exp 13", bus.disp_val); end
      wait_phase(20);
      checks++;
      if (bus.an !== 2'b01 || bus.seg !== 7'h79) begin
         errors++; $display("FAIL dig1_13: an=%b seg=%h exp 01/79", bus.an, bus.seg);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bus.an !== 2'b11 || bus.seg !== 7'h7F || bus.disp_val !== 4'd0) begin
         errors++;
         $display("FAIL async_rst: an=%b seg=%h disp=%0d exp 11/7f/0", bus.an, bus.seg, bus.disp_val);
      end
      @(negedge clk);
      rst = 1'b1;
      step(1);
      checks++;
      if (bus.an !== 2'b11 || bus.seg !== 7'h7F) begin
         errors++; $display("FAIL post_rst_blank: an=%b seg=%h exp 11/7f", bus.an, bus.seg);
      end
      step(1);
      checks++;
      if (bus.an !== 2'b10 || bus.seg !== 7'h40) begin
         errors++; $display("FAIL post_rst_dig0: an=%b seg=%h exp 10/40", bus.an, bus.seg);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset;
      test_val7;
      test_val12;
      test_glitch;
      test_wrap;
      test_reset_mid;
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
